// File: rtl/multadd_pkg.sv
// Shared types and constants for the multadd operand sequencer.
package multadd_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_FMA = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  // Cycles from multadd operands to multadd data_o.
  localparam int unsigned MULT_LAT = 1;

  // The reserved encoding behaves as ADD.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_op = OP_SUB;
      2'd2:    decode_op = OP_FMA;
      default: decode_op = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multadd_seq_pipe.sv
// Valid/index/first/last tracking from operand read through multadd result.
// Stage 0 is the cycle read data arrives; the last stage is the multadd result cycle.
module multadd_seq_pipe
  import multadd_pkg::*;
#(
  parameter int unsigned vlen_p   = 8,
  parameter int unsigned addr_w_p = $clog2(vlen_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                in_v_i,
  input  logic [addr_w_p-1:0] in_idx_i,
  input  logic                in_first_i,
  input  logic                in_last_i,
  output logic                issue_v_o,
  output logic                issue_first_o,
  output logic                res_v_o,
  output logic [addr_w_p-1:0] res_idx_o,
  output logic                res_last_o
);

  localparam int unsigned depth_lp = 2 + MULT_LAT;

  logic [depth_lp-1:0] v_q;
  logic [depth_lp-1:0] last_q;
  logic [addr_w_p-1:0] idx_q [depth_lp];
  logic                first_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q     <= '0;
      last_q  <= '0;
      first_q <= 1'b0;
      for (int k = 0; k < int'(depth_lp); k++) begin
        idx_q[k] <= '0;
      end
    end else begin
      v_q      <= {v_q[depth_lp-2:0], in_v_i};
      last_q   <= {last_q[depth_lp-2:0], in_v_i & in_last_i};
      first_q  <= in_v_i & in_first_i;
      idx_q[0] <= in_idx_i;
      for (int k = 1; k < int'(depth_lp); k++) begin
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  assign issue_v_o     = v_q[0];
  assign issue_first_o = first_q;
  assign res_v_o       = v_q[depth_lp-1];
  assign res_idx_o     = idx_q[depth_lp-1];
  assign res_last_o    = last_q[depth_lp-1];

endmodule

// File: rtl/multadd_seq.sv
// Vector command sequencer feeding the multadd lane and writing results back.
// Optional MULTADD_SEQ_STICKY_FLAGS_EN adds a sticky per-command overflow output ovf_o.
module multadd_seq
  import multadd_pkg::*;
#(
  parameter int unsigned vdw_p     = 32,
  parameter int unsigned vlen_p    = 8,
  parameter int unsigned lg_vlen_p = $clog2(vlen_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      cmd_v_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [lg_vlen_p-1:0]      cmd_len_i,
  output logic                      rd_v_o,
  output logic [$clog2(vlen_p)-1:0] rd_addr_o,
  input  logic [vdw_p-1:0]          a_data_i,
  input  logic [vdw_p-1:0]          b_data_i,
  output logic [vdw_p-1:0]          a_o,
  output logic [vdw_p-1:0]          b_o,
  output logic                      alu_op_o,
  output logic                      use_fma_o,
  output logic                      fma_first_o,
  input  logic [vdw_p-1:0]          mult_data_i,
  input  logic                      mult_ovf_i,
  output logic                      wr_v_o,
  output logic [$clog2(vlen_p)-1:0] wr_addr_o,
  output logic [vdw_p-1:0]          wr_data_o,
`ifdef MULTADD_SEQ_STICKY_FLAGS_EN
  output logic                      ovf_o,
`endif
  output logic                      done_o
);

  localparam int unsigned addr_w_lp = $clog2(vlen_p);

  state_e                 state_q;
  op_e                    op_q;
  logic [lg_vlen_p-1:0]   len_q;
  logic                   rd_v_q;
  logic [addr_w_lp-1:0]   rd_addr_q;
  logic                   ready_q;
  logic                   done_q;

  logic                   issue_v;
  logic                   issue_first;
  logic                   res_v;
  logic [addr_w_lp-1:0]   res_idx;
  logic                   res_last;

  logic [vdw_p-1:0]       a_q;
  logic [vdw_p-1:0]       b_q;
  logic                   alu_op_q;
  logic                   use_fma_q;
  logic                   fma_first_q;
  logic                   fma_wr_q;
  logic [vdw_p-1:0]       fma_res_q;

  logic                   is_fma;
  logic                   last_issue;
  logic                   drain_done;

  assign is_fma     = (op_q == OP_FMA);
  assign last_issue = ((lg_vlen_p'(rd_addr_q) + lg_vlen_p'(1)) == len_q);
  // FMA finishes on its single deferred write; element-wise on the last result.
  assign drain_done = is_fma ? fma_wr_q : (res_v & res_last);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      len_q     <= '0;
      rd_v_q    <= 1'b0;
      rd_addr_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_v_i) begin
            op_q      <= decode_op(cmd_op_i);
            len_q     <= cmd_len_i;
            ready_q   <= 1'b0;
            rd_addr_q <= '0;
            if (cmd_len_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              rd_v_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (last_issue) begin
            rd_v_q    <= 1'b0;
            rd_addr_q <= '0;
            state_q   <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  multadd_seq_pipe #(
    .vlen_p   (vlen_p),
    .addr_w_p (addr_w_lp)
  ) u_pipe (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .in_v_i        (rd_v_q),
    .in_idx_i      (rd_addr_q),
    .in_first_i    (rd_addr_q == '0),
    .in_last_i     (last_issue),
    .issue_v_o     (issue_v),
    .issue_first_o (issue_first),
    .res_v_o       (res_v),
    .res_idx_o     (res_idx),
    .res_last_o    (res_last)
  );

  // Operand slot; FMA keeps the last pair so the accumulator sees no stray operands.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_q         <= '0;
      b_q         <= '0;
      alu_op_q    <= 1'b0;
      use_fma_q   <= 1'b0;
      fma_first_q <= 1'b0;
    end else if (issue_v) begin
      a_q         <= a_data_i;
      b_q         <= b_data_i;
      alu_op_q    <= (op_q == OP_SUB);
      use_fma_q   <= is_fma;
      fma_first_q <= is_fma & issue_first;
    end else begin
      alu_op_q    <= 1'b0;
      use_fma_q   <= 1'b0;
      fma_first_q <= 1'b0;
      if (!is_fma) begin
        a_q <= '0;
        b_q <= '0;
      end
    end
  end

  // The final accumulate is captured on its result cycle and written the cycle after.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fma_wr_q  <= 1'b0;
      fma_res_q <= '0;
    end else begin
      fma_wr_q <= is_fma & res_v & res_last;
      if (is_fma && res_v && res_last) begin
        fma_res_q <= mult_data_i;
      end
    end
  end

  always_comb begin
    wr_v_o    = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (fma_wr_q) begin
      wr_v_o    = 1'b1;
      wr_data_o = fma_res_q;
    end else if (res_v && !is_fma) begin
      wr_v_o    = 1'b1;
      wr_addr_o = res_idx;
      wr_data_o = mult_data_i;
    end
  end

`ifdef MULTADD_SEQ_STICKY_FLAGS_EN
  logic ovf_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && cmd_v_i) begin
      ovf_q <= 1'b0;
    end else if (res_v && mult_ovf_i) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_mult_ovf;
  assign unused_mult_ovf = mult_ovf_i;
`endif

  assign cmd_ready_o = ready_q;
  assign done_o      = done_q;
  assign rd_v_o      = rd_v_q;
  assign rd_addr_o   = rd_addr_q;
  assign a_o         = a_q;
  assign b_o         = b_q;
  assign alu_op_o    = alu_op_q;
  assign use_fma_o   = use_fma_q;
  assign fma_first_o = fma_first_q;

endmodule
